// File: rtl/alu_sequencer.sv
// Operand/command sequencer for an 8-bit ALU.
// Collects operand A, operand B and a control word from one valid/ready input
// stream, holds them on registered ALU ports, waits a fixed settle time, then
// captures the ALU result and status into a valid/ready output register.
// Only one operation is in flight at a time.
module alu_sequencer #(
    parameter int WIDTH       = 8,  // must be >= 5 so the control word fits
    parameter int EXEC_CYCLES = 1   // settle cycles before capture, 1..15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_c_in,
    output logic [2:0]       alu_control_line,
    output logic             alu_mode_select,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_c_out,
    output logic [WIDTH-1:0] out_data,
    output logic             out_c_out,
    output logic             out_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       op_count
);

    typedef enum logic [2:0] {
        LOAD_A    = 3'd0,
        LOAD_B    = 3'd1,
        LOAD_CTRL = 3'd2,
        EXEC      = 3'd3,
        RESULT    = 3'd4
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] cnt_r;
    logic       in_xfer_s;
    logic       load_a_s;
    logic       load_b_s;
    logic       load_ctrl_s;
    logic       capture_s;
    logic       out_xfer_s;

    // Input handshake: only the three load states accept data, never during reset.
    always_comb begin
        in_ready = 1'b0;
        if (rst) begin
            in_ready = 1'b0;
        end else if ((state_r == LOAD_A) || (state_r == LOAD_B) || (state_r == LOAD_CTRL)) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
    end

    // Next-state and per-cycle strobes; abort overrides every transfer.
    always_comb begin
        next_state_s = state_r;
        in_xfer_s    = in_valid && in_ready && !abort;
        load_a_s     = 1'b0;
        load_b_s     = 1'b0;
        load_ctrl_s  = 1'b0;
        capture_s    = 1'b0;
        out_xfer_s   = 1'b0;
        if (abort) begin
            next_state_s = LOAD_A;
        end else begin
            case (state_r)
                LOAD_A: begin
                    load_a_s = in_xfer_s;
                    if (in_xfer_s) next_state_s = LOAD_B;
                    else           next_state_s = LOAD_A;
                end
                LOAD_B: begin
                    load_b_s = in_xfer_s;
                    if (in_xfer_s) next_state_s = LOAD_CTRL;
                    else           next_state_s = LOAD_B;
                end
                LOAD_CTRL: begin
                    load_ctrl_s = in_xfer_s;
                    if (in_xfer_s) next_state_s = EXEC;
                    else           next_state_s = LOAD_CTRL;
                end
                EXEC: begin
                    capture_s = (cnt_r == LAST_CNT);
                    if (cnt_r == LAST_CNT) next_state_s = RESULT;
                    else                   next_state_s = EXEC;
                end
                RESULT: begin
                    out_xfer_s = out_valid && out_ready;
                    if (out_valid && out_ready) next_state_s = LOAD_A;
                    else                        next_state_s = RESULT;
                end
                default: begin
                    next_state_s = LOAD_A;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= LOAD_A;
        else     state_r <= next_state_s;
    end

    // Settle counter: runs only while in EXEC, zero everywhere else so entry starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                cnt_r <= 4'd0;
        else if (abort)                         cnt_r <= 4'd0;
        else if ((state_r == EXEC) && !capture_s) cnt_r <= cnt_r + 4'd1;
        else                                    cnt_r <= 4'd0;
    end

    // ALU port registers: written only on load transfers, so they hold through EXEC/RESULT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a            <= {WIDTH{1'b0}};
            alu_b            <= {WIDTH{1'b0}};
            alu_control_line <= 3'd0;
            alu_mode_select  <= 1'b0;
            alu_c_in         <= 1'b0;
        end else begin
            if (load_a_s) alu_a <= in_data;
            if (load_b_s) alu_b <= in_data;
            if (load_ctrl_s) begin
                alu_control_line <= in_data[2:0];
                alu_mode_select  <= in_data[3];
                alu_c_in         <= in_data[4];
            end
        end
    end

    // Result capture: data/status persist until the next capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= {WIDTH{1'b0}};
            out_c_out <= 1'b0;
            out_zero  <= 1'b0;
        end else if (capture_s) begin
            out_data  <= alu_out;
            out_c_out <= alu_c_out;
            out_zero  <= (alu_out == {WIDTH{1'b0}});
        end else begin
            out_data  <= out_data;
            out_c_out <= out_c_out;
            out_zero  <= out_zero;
        end
    end

    // Output valid flag and completed-operation counter (abort suppresses both).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            op_count  <= 8'd0;
        end else if (abort) begin
            out_valid <= 1'b0;
        end else if (capture_s) begin
            out_valid <= 1'b1;
        end else if (out_xfer_s) begin
            out_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule
